main_hpf_dac: RTL and testbench
===============================

MAIN_HPF_DAC -- requirements
Module: main_hpf_dac

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 2, meaning clk1_in cycles per DAC_SCLK half-period (legal 1..255).
REQ-002 SHALL have port clk1_in, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sample_valid, input, 1, one-cycle strobe qualifying sample_dac and sample_data.
REQ-005 SHALL have port sample_dac, input, 3, target DAC index 0..7.
REQ-006 SHALL have port sample_data, input, 16, amplifier sample in offset binary (0x8000 = zero).
REQ-007 SHALL have port hpf_en, input, 1, global high-pass filter enable.
REQ-008 SHALL have port hpf_coeff, input, 16, unsigned HPF coefficient (fraction of 2^16).
REQ-009 SHALL have port dac_en, input, 8, per-DAC enable; bit i drives DAC_DIN_(i+1).
REQ-010 SHALL have port frame_start, input, 1, one-cycle strobe requesting a DAC update frame.
REQ-011 SHALL have ports DAC_SYNC, DAC_SCLK, output, 1 each, shared DAC frame sync (active low) and serial clock.
REQ-012 SHALL have ports DAC_DIN_1..DAC_DIN_8, output, 1 each, serial data per DAC.
REQ-013 SHALL have port busy, output, 1, high while a frame is in flight.

Function
REQ-014 SHALL convert accepted samples to signed x = sample_data with MSB inverted.
REQ-015 SHALL keep one 16-bit signed HPF state per DAC.
REQ-016 With hpf_en=1, SHALL compute y = sat16(x - state) and state <= sat16(state + floor((hpf_coeff * y) / 2^16)), using at least 33-bit signed intermediates.
REQ-017 With hpf_en=0, SHALL set y = x and hold that DAC's state at 0.
REQ-018 SHALL saturate to [-32768, 32767] and never wrap.
REQ-019 SHALL write word[i] = y with MSB inverted into the output register of the addressed DAC exactly 1 cycle after sample_valid; other DACs are unchanged.
REQ-020 SHALL use state IDLE -> SHIFT on frame_start in IDLE, and snapshot all 8 words in the same cycle.
REQ-021 SHALL transmit in SHIFT 24 bits per DAC, MSB first: 8 zero bits (6 don't-care, PD1:PD0 = 00), then the 16-bit word.
REQ-022 SHALL substitute 0x8000 (midscale) at snapshot for any DAC with dac_en[i]=0.
REQ-023 SHALL hold DAC_SYNC low for all 24 bits; DAC_SCLK idles low; DIN changes on SCLK rising edge and is stable at the falling edge.
REQ-024 SHALL move SHIFT -> GAP after the 24th falling edge, hold DAC_SYNC high for 1 SCLK period, then return to IDLE.
REQ-025 SHALL make a frame last 50*SCLK_DIV clk1_in cycles; busy = (state != IDLE).
REQ-026 SHALL ignore frame_start while busy.
REQ-027 SHALL let sample_valid during a frame update the output registers only; the in-flight frame uses the snapshot.
REQ-028 SHALL give frame_start and sample_valid in the same IDLE cycle an old-word snapshot; the new word appears in the next frame.

Reset
REQ-029 While reset_n=0, SHALL hold HPF states at 0, output words at 0x8000, state IDLE, DAC_SYNC=1, DAC_SCLK=0, all DAC_DIN=0, busy=0.
REQ-030 Reset mid-frame SHALL abort immediately; no partial frame resumes after release.

Structure
REQ-031 SHALL place in a shared package: frame state enum (IDLE/SHIFT/GAP), FRAME_BITS=24, MIDSCALE=16'h8000, and the sat16 function.
REQ-032 SHALL implement the serializer (snapshot, SCLK divider, shift registers, FSM) as sub-module dac_serializer_8ch; HPF and output registers stay in main_hpf_dac.

Verification
REQ-033 Release reset, then pulse frame_start -> all 8 DIN shift 0x008000, SYNC low for 24 SCLK periods, busy low after 50*SCLK_DIV cycles.
REQ-034 hpf_en=0, dac_en=0xFF, sample 0x9000 to DAC 2, then frame -> DAC_DIN_3 shifts 0x009000; others 0x008000.
REQ-035 hpf_en=1, coeff 0x8000, three samples 0xA000 to DAC 0 -> successive words 0xA000, 0x9000, 0x8800.
REQ-036 hpf_en=1, coeff 0xFFFF, DAC 1 sample 0x0000 then 0xFFFF -> words 0x0000 then saturated 0xFFFF.
REQ-037 dac_en=0xFE with DAC 0 word 0x9000 -> DAC_DIN_1 shifts 0x008000.
REQ-038 frame_start mid-frame -> ignored, frame length unchanged; reset_n low mid-frame -> DAC_SYNC=1, SCLK=0 at once.

Source files
------------

// File: rtl/main_hpf_dac_pkg.sv
// Shared types, constants and saturation helper for the HPF/DAC front end.
package main_hpf_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } frame_state_e;

  localparam int          FRAME_BITS = 24;
  localparam int          NUM_DACS   = 8;
  localparam logic [15:0] MIDSCALE   = 16'h8000;

  // Width of the signed HPF intermediates; leaves headroom above the 33-bit product.
  localparam int WIDE_W = 34;

  localparam logic signed [WIDE_W-1:0] SAT_MAX = 34'sd32767;
  localparam logic signed [WIDE_W-1:0] SAT_MIN = -34'sd32768;

  function automatic logic signed [15:0] sat16(input logic signed [WIDE_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < SAT_MIN) begin
      return 16'h8000;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/dac_serializer_8ch.sv
// Snapshots eight DAC words and shifts them out as 24-bit frames on a shared SYNC/SCLK.
module dac_serializer_8ch
  import main_hpf_dac_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic [NUM_DACS-1:0]           dac_en,
  input  logic [NUM_DACS-1:0][15:0]     words,
  output logic                          sync_n,
  output logic                          sclk,
  output logic [NUM_DACS-1:0]           din,
  output logic                          busy
);

  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [5:0] SHIFT_LAST = 6'(2 * FRAME_BITS - 1);

  frame_state_e                         state_q, state_d;
  logic [7:0]                           div_cnt_q;
  logic [5:0]                           half_cnt_q;
  logic [NUM_DACS-1:0][FRAME_BITS-1:0]  shreg_q;
  logic                                 half_end;

  assign half_end = (div_cnt_q == DIV_LAST);
  assign busy     = (state_q != IDLE);

  // NOTE: state_d is given its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = SHIFT;
      SHIFT:   if (half_end && (half_cnt_q == SHIFT_LAST)) state_d = GAP;
      GAP:     if (half_end && half_cnt_q[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all of them update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      shreg_q    <= '0;
      sclk       <= 1'b0;
      sync_n     <= 1'b1;
      din        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          div_cnt_q  <= '0;
          half_cnt_q <= '0;
          if (frame_start) begin
            sync_n <= 1'b0;
            for (int i = 0; i < NUM_DACS; i++) begin
              shreg_q[i] <= {8'h00, (dac_en[i] ? words[i] : MIDSCALE)};
            end
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt_q <= '0;
            // Even half-periods are SCLK-low; ending one raises SCLK and presents the next bit.
            if (!half_cnt_q[0]) begin
              sclk <= 1'b1;
              for (int i = 0; i < NUM_DACS; i++) begin
                din[i]     <= shreg_q[i][FRAME_BITS-1];
                shreg_q[i] <= {shreg_q[i][FRAME_BITS-2:0], 1'b0};
              end
            end else begin
              sclk <= 1'b0;
            end
            if (state_d == GAP) begin
              half_cnt_q <= '0;
              sync_n     <= 1'b1;
            end else begin
              half_cnt_q <= half_cnt_q + 6'd1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (half_end) begin
            div_cnt_q  <= '0;
            half_cnt_q <= half_cnt_q + 6'd1;
            if (state_d == IDLE) din <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/main_hpf_dac.sv
// Per-DAC high-pass filter and output word registers feeding an 8-channel serial DAC frame.
module main_hpf_dac
  import main_hpf_dac_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic        clk1_in,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [2:0]  sample_dac,
  input  logic [15:0] sample_data,
  input  logic        hpf_en,
  input  logic [15:0] hpf_coeff,
  input  logic [7:0]  dac_en,
  input  logic        frame_start,
  output logic        DAC_SYNC,
  output logic        DAC_SCLK,
  output logic        DAC_DIN_1,
  output logic        DAC_DIN_2,
  output logic        DAC_DIN_3,
  output logic        DAC_DIN_4,
  output logic        DAC_DIN_5,
  output logic        DAC_DIN_6,
  output logic        DAC_DIN_7,
  output logic        DAC_DIN_8,
  output logic        busy
);

  logic [NUM_DACS-1:0][15:0] hpf_state_q;
  logic [NUM_DACS-1:0][15:0] word_q;
  logic [NUM_DACS-1:0]       din;

  logic signed [15:0]       x, cur_state, y, next_state;
  logic signed [WIDE_W-1:0] diff, sum;
  logic signed [32:0]       prod, step;

  always_comb begin
    x          = {~sample_data[15], sample_data[14:0]};
    cur_state  = hpf_state_q[sample_dac];
    diff       = WIDE_W'(x) - WIDE_W'(cur_state);
    y          = hpf_en ? sat16(diff) : x;
    // Unsigned coefficient widened with a zero MSB so the product stays signed.
    prod       = $signed({1'b0, hpf_coeff}) * y;
    step       = prod >>> 16;
    sum        = WIDE_W'(cur_state) + WIDE_W'(step);
    next_state = hpf_en ? sat16(sum) : 16'sd0;
  end

  // NOTE: the filter states are reset with the word registers; a filter must not start from garbage.
  always_ff @(posedge clk1_in or negedge reset_n) begin
    if (!reset_n) begin
      hpf_state_q <= '0;
      word_q      <= {NUM_DACS{MIDSCALE}};
    end else if (sample_valid) begin
      hpf_state_q[sample_dac] <= next_state;
      word_q[sample_dac]      <= {~y[15], y[14:0]};
    end
  end

  dac_serializer_8ch #(
    .SCLK_DIV (SCLK_DIV)
  ) u_serializer (
    .clk         (clk1_in),
    .rst_n       (reset_n),
    .frame_start (frame_start),
    .dac_en      (dac_en),
    .words       (word_q),
    .sync_n      (DAC_SYNC),
    .sclk        (DAC_SCLK),
    .din         (din),
    .busy        (busy)
  );

  assign DAC_DIN_1 = din[0];
  assign DAC_DIN_2 = din[1];
  assign DAC_DIN_3 = din[2];
  assign DAC_DIN_4 = din[3];
  assign DAC_DIN_5 = din[4];
  assign DAC_DIN_6 = din[5];
  assign DAC_DIN_7 = din[6];
  assign DAC_DIN_8 = din[7];

endmodule

// File: tb/tb_main_hpf_dac.sv
// Scoreboard bench: frames expected at frame_start are compared with bits captured on SCLK falls.
`timescale 1ns/1ps
module tb_main_hpf_dac;

  localparam int D = 2;

  typedef logic [7:0][23:0] frame_t;

  logic        clk1_in = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [2:0]  sample_dac;
  logic [15:0] sample_data;
  logic        hpf_en;
  logic [15:0] hpf_coeff;
  logic [7:0]  dac_en;
  logic        frame_start;
  logic        DAC_SYNC, DAC_SCLK, busy;
  logic        DAC_DIN_1, DAC_DIN_2, DAC_DIN_3, DAC_DIN_4;
  logic        DAC_DIN_5, DAC_DIN_6, DAC_DIN_7, DAC_DIN_8;
  logic [7:0]  din_vec;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t      exp_q[$];
  logic [15:0] m_word [8];
  int          m_state[8];

  main_hpf_dac #(.SCLK_DIV(D)) dut (
    .clk1_in      (clk1_in),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_dac   (sample_dac),
    .sample_data  (sample_data),
    .hpf_en       (hpf_en),
    .hpf_coeff    (hpf_coeff),
    .dac_en       (dac_en),
    .frame_start  (frame_start),
    .DAC_SYNC     (DAC_SYNC),
    .DAC_SCLK     (DAC_SCLK),
    .DAC_DIN_1    (DAC_DIN_1),
    .DAC_DIN_2    (DAC_DIN_2),
    .DAC_DIN_3    (DAC_DIN_3),
    .DAC_DIN_4    (DAC_DIN_4),
    .DAC_DIN_5    (DAC_DIN_5),
    .DAC_DIN_6    (DAC_DIN_6),
    .DAC_DIN_7    (DAC_DIN_7),
    .DAC_DIN_8    (DAC_DIN_8),
    .busy         (busy)
  );

  assign din_vec = {DAC_DIN_8, DAC_DIN_7, DAC_DIN_6, DAC_DIN_5,
                    DAC_DIN_4, DAC_DIN_3, DAC_DIN_2, DAC_DIN_1};

  always #5 clk1_in = ~clk1_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Integer reference of the filter; floor division done explicitly.
  function automatic void model_sample(input int dac, input logic [15:0] data);
    int     x, y, st;
    longint prod, step;
    x = int'(data) - 32768;
    if (hpf_en) begin
      st   = m_state[dac];
      y    = sat(longint'(x) - st);
      prod = longint'(hpf_coeff) * y;
      step = prod / 65536;
      if ((prod % 65536) != 0 && prod < 0) step = step - 1;
      m_state[dac] = sat(st + step);
    end else begin
      y = x;
      m_state[dac] = 0;
    end
    m_word[dac] = 16'(y + 32768);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_word[i]  = 16'h8000;
      m_state[i] = 0;
    end
  endfunction

  function automatic void push_expected();
    frame_t f;
    for (int i = 0; i < 8; i++) f[i] = {8'h00, (dac_en[i] ? m_word[i] : 16'h8000)};
    exp_q.push_back(f);
  endfunction

  // Frame monitor: capture DIN after every SCLK fall, compare each completed 24-bit frame.
  int          bit_cnt   = 0;
  int          frame_no  = 0;
  logic        sclk_prev = 1'b0;
  logic [23:0] cap[8];

  always @(negedge clk1_in) begin
    if (!reset_n) begin
      bit_cnt   = 0;
      sclk_prev = 1'b0;
    end else begin
      if (sclk_prev && !DAC_SCLK) begin
        for (int ch = 0; ch < 8; ch++) cap[ch] = {cap[ch][22:0], din_vec[ch]};
        bit_cnt++;
        if (bit_cnt == 24) begin
          frame_t e;
          if (exp_q.size() == 0) begin
            check($sformatf("frame%0d_unexpected", frame_no), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            for (int ch = 0; ch < 8; ch++)
              check($sformatf("frame%0d_din%0d", frame_no, ch + 1), {8'h00, cap[ch]}, {8'h00, e[ch]});
          end
          frame_no++;
          bit_cnt = 0;
        end
      end
      sclk_prev = DAC_SCLK;
    end
  end

  task automatic send_sample(input logic [2:0] d, input logic [15:0] v);
    @(negedge clk1_in);
    sample_valid = 1'b1;
    sample_dac   = d;
    sample_data  = v;
    model_sample(int'(d), v);
    @(negedge clk1_in);
    sample_valid = 1'b0;
  endtask

  task automatic run_frame(input int mid_start_at, input int mid_sample_at, input bit co_sample,
                           input logic [2:0] s_dac, input logic [15:0] s_data);
    int busy_cyc, sync_cyc;
    @(negedge clk1_in);
    frame_start = 1'b1;
    push_expected();
    if (co_sample) begin
      sample_valid = 1'b1;
      sample_dac   = s_dac;
      sample_data  = s_data;
      model_sample(int'(s_dac), s_data);
    end
    @(negedge clk1_in);
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    busy_cyc = 0;
    sync_cyc = 0;
    while (busy && busy_cyc < 1000) begin
      busy_cyc++;
      if (!DAC_SYNC) sync_cyc++;
      frame_start  = (busy_cyc == mid_start_at);
      sample_valid = (busy_cyc == mid_sample_at);
      if (busy_cyc == mid_sample_at) begin
        sample_dac  = s_dac;
        sample_data = s_data;
        model_sample(int'(s_dac), s_data);
      end
      @(negedge clk1_in);
    end
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    check("busy_cycles", busy_cyc, 50 * D);
    check("sync_low_cycles", sync_cyc, 48 * D);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_dac   = '0;
    sample_data  = '0;
    hpf_en       = 1'b0;
    hpf_coeff    = '0;
    dac_en       = 8'hFF;
    frame_start  = 1'b0;
    model_reset();

    repeat (3) @(negedge clk1_in);
    check("rst_sync", DAC_SYNC, 1);
    check("rst_sclk", DAC_SCLK, 0);
    check("rst_din", din_vec, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk1_in);

    // All-midscale frame straight out of reset.
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    // Filter bypassed: DAC 2 gets the raw sample.
    hpf_en = 1'b0;
    send_sample(3'd2, 16'h9000);
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    // Half-coefficient filter on a step: 0xA000, 0x9000, 0x8800.
    hpf_en    = 1'b1;
    hpf_coeff = 16'h8000;
    for (int k = 0; k < 3; k++) begin
      send_sample(3'd0, 16'hA000);
      run_frame(-1, -1, 0, 3'd0, 16'h0);
    end

    // Full-swing step into saturation on DAC 1.
    hpf_coeff = 16'hFFFF;
    send_sample(3'd1, 16'h0000);
    run_frame(-1, -1, 0, 3'd0, 16'h0);
    send_sample(3'd1, 16'hFFFF);
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    // Disabled DAC 0 goes out as midscale.
    hpf_en = 1'b0;
    send_sample(3'd0, 16'h9000);
    dac_en = 8'hFE;
    run_frame(-1, -1, 0, 3'd0, 16'h0);
    dac_en = 8'hFF;

    // frame_start while busy is ignored.
    run_frame(40, -1, 0, 3'd0, 16'h0);

    // Sample during a frame lands in the next frame only.
    run_frame(-1, 30, 0, 3'd3, 16'h1234);
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    // Sample in the same cycle as frame_start: old word now, new word next frame.
    run_frame(-1, -1, 1, 3'd4, 16'h7777);
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    for (int it = 0; it < 6; it++) begin
      hpf_en    = 1'($urandom_range(0, 1));
      hpf_coeff = 16'($urandom);
      dac_en    = 8'($urandom);
      repeat (3) send_sample(3'($urandom_range(0, 7)), 16'($urandom));
      run_frame(-1, -1, 0, 3'd0, 16'h0);
    end

    // Reset in the middle of a frame aborts it at once.
    @(negedge clk1_in);
    frame_start = 1'b1;
    push_expected();
    @(negedge clk1_in);
    frame_start = 1'b0;
    repeat (30) @(negedge clk1_in);
    reset_n = 1'b0;
    #1;
    check("abort_sync", DAC_SYNC, 1);
    check("abort_sclk", DAC_SCLK, 0);
    check("abort_din", din_vec, 0);
    check("abort_busy", busy, 0);
    void'(exp_q.pop_back());
    model_reset();
    repeat (3) @(negedge clk1_in);
    reset_n = 1'b1;
    seen = 0;
    repeat (120) begin
      @(negedge clk1_in);
      if (busy || !DAC_SYNC || DAC_SCLK) seen = 1;
    end
    check("no_resume", seen, 0);

    dac_en = 8'hFF;
    run_frame(-1, -1, 0, 3'd0, 16'h0);

    repeat (4) @(negedge clk1_in);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
